data_bus_responder: RTL and testbench

//  Slave end of the core's data-memory port: answers MemAddress/MemWriteData/MemWrite with MemReadData.

---
 rtl/cpu_bus_pkg.sv | 32 +++
 rtl/uart_tx_byte.sv | 86 ++++++++
 rtl/data_bus_responder.sv | 146 ++++++++++++++
 tb/tb_data_bus_responder.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the data-memory bus responder.
// Holds the default address bases, the word index of each MMIO register
// inside the 32-byte peripheral window, the TCON bit positions and the UART
// transmitter state encoding.
package cpu_bus_pkg;

  localparam logic [31:0] DATA_BASE_DEF = 32'h1001_0000;
  localparam logic [31:0] MMIO_BASE_DEF = 32'h4000_0000;
  localparam logic [31:0] MMIO_SPAN     = 32'd32;

  // Word index within the MMIO window (byte offset >> 2)
  localparam logic [2:0] REG_TH        = 3'd0;
  localparam logic [2:0] REG_TL        = 3'd1;
  localparam logic [2:0] REG_TCON      = 3'd2;
  localparam logic [2:0] REG_LED       = 3'd3;
  localparam logic [2:0] REG_DIGI      = 3'd4;
  localparam logic [2:0] REG_SYSTICK   = 3'd5;
  localparam logic [2:0] REG_UART_TXD  = 3'd6;
  localparam logic [2:0] REG_UART_STAT = 3'd7;

  localparam int TCON_EN       = 0;
  localparam int TCON_IRQ_EN   = 1;
  localparam int TCON_IRQ_STAT = 2;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serial transmitter: one start bit, eight data bits LSB first, one stop
// bit, each held BAUD_DIV clock cycles.
// Ports: clk, reset (async, active-high), start (accepted only when idle),
//        data[7:0] (latched on an accepted start), busy (frame in progress),
//        txd (serial line, idle high).
module uart_tx_byte
  import cpu_bus_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       txd
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  uart_state_t   state;
  uart_state_t   state_next;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          baud_done;

  assign baud_done = (baud_cnt == BAUD_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= UART_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      UART_IDLE:  if (start) state_next = UART_START; else state_next = UART_IDLE;
      UART_START: if (baud_done) state_next = UART_DATA; else state_next = UART_START;
      UART_DATA:  if (baud_done && (bit_cnt == 3'd7)) state_next = UART_STOP;
                  else state_next = UART_DATA;
      UART_STOP:  if (baud_done) state_next = UART_IDLE; else state_next = UART_STOP;
      default:    state_next = UART_IDLE;
    endcase
  end

  // Output decode; shreg[0] always holds the bit currently on the line
  always_comb begin
    busy = (state != UART_IDLE);
    case (state)
      UART_IDLE:  txd = 1'b1;
      UART_START: txd = 1'b0;
      UART_DATA:  txd = shreg[0];
      UART_STOP:  txd = 1'b1;
      default:    txd = 1'b1;
    endcase
  end

  // Bit timer, bit counter and shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
    end else if (state == UART_IDLE) begin
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      if (start) shreg <= data;
    end else if (baud_done) begin
      baud_cnt <= '0;
      if (state == UART_DATA) begin
        shreg   <= {1'b0, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end else begin
      baud_cnt <= baud_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/data_bus_responder.sv
// Slave end of the core's data-memory port: data RAM plus a 32-byte MMIO
// window (timer with interrupt, LED, 7-seg, free-running systick, optional
// UART transmitter). Reads are combinational from mem_address so the core can
// capture them into MEM/WB on the next edge; writes commit on the rising edge.
// Ports: clk, reset (async, active-high), mem_write, mem_address[31:0],
//        mem_write_data[31:0], mem_read_data[31:0], irq (= TCON[2]),
//        leds[7:0], digits[11:0] ([11:8] anodes, [7:0] segments), uart_txd.
// Build option: define DATA_BUS_UART_TX_EN to include the UART transmitter at
// +18 (TXD) / +1C (STAT); otherwise uart_txd is held high and both read 0.
module data_bus_responder
  import cpu_bus_pkg::*;
#(
  parameter int          RAM_WORDS = 512,
  parameter logic [31:0] DATA_BASE = DATA_BASE_DEF,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
  parameter int          BAUD_DIV  = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        irq,
  output logic [7:0]  leds,
  output logic [11:0] digits,
  output logic        uart_txd
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) * 32'd4;

  logic [31:0]       ram [RAM_WORDS];
  logic [31:0]       ram_off;
  logic [31:0]       mmio_off;
  logic              ram_hit;
  logic              mmio_hit;
  logic [RAM_AW-1:0] ram_idx;
  logic [2:0]        reg_sel;
  logic              wr_reg;

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] systick;
  logic [31:0] tl_next;
  logic [2:0]  tcon_next;
  logic        tl_max;
  logic        irq_set;
  logic        uart_busy;

  // Offsets relative to each base; an unsigned compare covers both bounds
  assign ram_off  = mem_address - DATA_BASE;
  assign mmio_off = mem_address - MMIO_BASE;
  assign ram_hit  = (ram_off < RAM_BYTES);
  assign mmio_hit = (mmio_off < MMIO_SPAN);
  assign ram_idx  = ram_off[RAM_AW+1:2];
  assign reg_sel  = mmio_off[4:2];
  assign wr_reg   = mem_write & mmio_hit;

  assign tl_max  = (tl == 32'hFFFF_FFFF);
  assign irq_set = tcon[TCON_EN] & tl_max & tcon[TCON_IRQ_EN];
  assign irq     = tcon[TCON_IRQ_STAT];

  // Timer next state: software TL write beats count/reload, and the reload
  // takes the TH value held before this edge
  always_comb begin
    if (wr_reg && (reg_sel == REG_TL)) begin
      tl_next = mem_write_data;
    end else if (tcon[TCON_EN]) begin
      if (tl_max) tl_next = th;
      else        tl_next = tl + 32'd1;
    end else begin
      tl_next = tl;
    end
    if (wr_reg && (reg_sel == REG_TCON)) tcon_next = mem_write_data[2:0];
    else                                 tcon_next = tcon;
    // A hardware set wins over a clearing write so no interrupt is lost
    tcon_next[TCON_IRQ_STAT] = tcon_next[TCON_IRQ_STAT] | irq_set;
  end

  // Peripheral registers and free-running systick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th      <= 32'h0;
      tl      <= 32'h0;
      tcon    <= 3'b000;
      leds    <= 8'h00;
      digits  <= 12'h000;
      systick <= 32'h0;
    end else begin
      tl      <= tl_next;
      tcon    <= tcon_next;
      systick <= systick + 32'd1;
      if (wr_reg && (reg_sel == REG_TH))   th     <= mem_write_data;
      if (wr_reg && (reg_sel == REG_LED))  leds   <= mem_write_data[7:0];
      if (wr_reg && (reg_sel == REG_DIGI)) digits <= mem_write_data[11:0];
    end
  end

  // Data RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_write && ram_hit) ram[ram_idx] <= mem_write_data;
  end

  // Combinational read mux; narrow registers zero-extend, unmapped reads 0
  always_comb begin
    mem_read_data = 32'h0;
    if (ram_hit) begin
      mem_read_data = ram[ram_idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        REG_TH:        mem_read_data = th;
        REG_TL:        mem_read_data = tl;
        REG_TCON:      mem_read_data = {29'h0, tcon};
        REG_LED:       mem_read_data = {24'h0, leds};
        REG_DIGI:      mem_read_data = {20'h0, digits};
        REG_SYSTICK:   mem_read_data = systick;
        REG_UART_STAT: mem_read_data = {31'h0, uart_busy};
        default:       mem_read_data = 32'h0;
      endcase
    end else begin
      mem_read_data = 32'h0;
    end
  end

`ifdef DATA_BUS_UART_TX_EN
  logic wr_uart;
  assign wr_uart = wr_reg & (reg_sel == REG_UART_TXD);

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart (
    .clk   (clk),
    .reset (reset),
    .start (wr_uart),
    .data  (mem_write_data[7:0]),
    .busy  (uart_busy),
    .txd   (uart_txd)
  );
`else
  assign uart_busy = 1'b0;
  assign uart_txd  = 1'b1;
`endif

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder. A behavioural model (associative
// RAM plus plain register variables advanced once per clock) predicts every
// read and output; directed tasks cover the timer, decode and reset corners,
// and a randomized sweep mixes RAM and register traffic.
module tb_data_bus_responder;

  localparam logic [31:0] DB = 32'h1001_0000;
  localparam logic [31:0] MB = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_write = 1'b0;
  logic [31:0] mem_address = 32'h0;
  logic [31:0] mem_write_data = 32'h0;
  logic [31:0] mem_read_data;
  logic        irq;
  logic [7:0]  leds;
  logic [11:0] digits;
  logic        uart_txd;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  logic [31:0] ram_m [int];
  logic [31:0] m_th, m_tl, m_systick;
  logic [2:0]  m_tcon;
  logic [7:0]  m_led;
  logic [11:0] m_digi;

  data_bus_responder #(
    .RAM_WORDS (512),
    .DATA_BASE (DB),
    .MMIO_BASE (MB),
    .BAUD_DIV  (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .irq            (irq),
    .leds           (leds),
    .digits         (digits),
    .uart_txd       (uart_txd)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_th = 32'h0; m_tl = 32'h0; m_tcon = 3'b000;
    m_led = 8'h00; m_digi = 12'h000; m_systick = 32'h0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, output bit valid);
    logic [31:0] orr, om;
    orr = a - DB;
    om  = a - MB;
    valid = 1'b1;
    model_read = 32'h0;
    if (orr < 32'd2048) begin
      if (ram_m.exists(int'(orr >> 2))) model_read = ram_m[int'(orr >> 2)];
      else valid = 1'b0;
    end else if (om < 32'd32) begin
      case (om[4:2])
        3'd0: model_read = m_th;
        3'd1: model_read = m_tl;
        3'd2: model_read = {29'h0, m_tcon};
        3'd3: model_read = {24'h0, m_led};
        3'd4: model_read = {20'h0, m_digi};
        3'd5: model_read = m_systick;
        default: model_read = 32'h0;
      endcase
    end
  endfunction

  // Advance model by one clock from the current bus inputs, then clock the DUT
  task automatic tick();
    logic [31:0] orr, om, nth, ntl;
    logic [2:0]  ntcon;
    logic        set;
    if (reset) begin
      @(posedge clk);
      model_reset();
    end else begin
      nth = m_th; ntl = m_tl; ntcon = m_tcon; set = 1'b0;
      if (m_tcon[0]) begin
        if (m_tl == 32'hFFFF_FFFF) begin ntl = m_th; set = m_tcon[1]; end
        else ntl = m_tl + 32'd1;
      end
      orr = mem_address - DB;
      om  = mem_address - MB;
      @(posedge clk);
      if (mem_write) begin
        if (orr < 32'd2048) ram_m[int'(orr >> 2)] = mem_write_data;
        else if (om < 32'd32) begin
          case (om[4:2])
            3'd0: nth = mem_write_data;
            3'd1: ntl = mem_write_data;
            3'd2: ntcon = mem_write_data[2:0];
            3'd3: m_led = mem_write_data[7:0];
            3'd4: m_digi = mem_write_data[11:0];
            default: ;
          endcase
        end
      end
      ntcon[2] = ntcon[2] | set;
      m_th = nth; m_tl = ntl; m_tcon = ntcon;
      m_systick = m_systick + 32'd1;
    end
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1; mem_address = a; mem_write_data = d;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a);
    mem_write = 1'b0; mem_address = a;
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({irq, leds, digits, uart_txd} !== {1'b0, 8'h00, 12'h000, 1'b1}) begin
      $display("FAIL reset_outputs: got irq=%b leds=%h digits=%h txd=%b, want 0/00/000/1", irq, leds, digits, uart_txd);
      errors++;
    end
    peek(MB + 32'h4);
    vectors++;
    if (mem_read_data !== 32'h0) begin
      $display("FAIL reset_tl: got %h want 00000000", mem_read_data); errors++;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    repeat (3) tick();
    peek(MB + 32'h14);
    vectors++;
    if (mem_read_data !== 32'd3) begin
      $display("FAIL systick_start: got %0d want 3", mem_read_data); errors++;
    end
  endtask

  task automatic test_ram();
    bus_write(DB + 32'h4, 32'hDEAD_BEEF);
    peek(DB + 32'h4);
    vectors++;
    if (mem_read_data !== 32'hDEAD_BEEF) begin
      $display("FAIL ram_read_04: got %h want DEADBEEF", mem_read_data); errors++;
    end
    peek(DB + 32'h7);
    vectors++;
    if (mem_read_data !== 32'hDEAD_BEEF) begin
      $display("FAIL ram_read_07: got %h want DEADBEEF", mem_read_data); errors++;
    end
  endtask

  task automatic test_timer();
    bus_write(MB + 32'h0, 32'hFFFF_FFFC);
    bus_write(MB + 32'h4, 32'hFFFF_FFFC);
    bus_write(MB + 32'h8, 32'h3);
    for (int k = 1; k <= 4; k++) begin
      tick();
      vectors++;
      if (irq !== (k == 4)) begin
        $display("FAIL timer_irq_cycle%0d: got %b want %b", k, irq, (k == 4)); errors++;
      end
    end
    peek(MB + 32'h4);
    vectors++;
    if (mem_read_data !== 32'hFFFF_FFFC) begin
      $display("FAIL timer_reload: got %h want FFFFFFFC", mem_read_data); errors++;
    end
    bus_write(MB + 32'h8, 32'h3);
    vectors++;
    if (irq !== 1'b0) begin
      $display("FAIL timer_irq_clear: got %b want 0", irq); errors++;
    end
  endtask

  task automatic test_collision();
    // TL is FFFF_FFFD here; two counts bring it to the reload cycle
    repeat (2) tick();
    bus_write(MB + 32'h8, 32'h3);
    vectors++;
    if (irq !== 1'b1) begin
      $display("FAIL collision_irq: got %b want 1", irq); errors++;
    end
    repeat (3) tick();
    bus_write(MB + 32'h0, 32'h0000_1234);
    peek(MB + 32'h4);
    vectors++;
    if (mem_read_data !== 32'hFFFF_FFFC || mem_read_data !== m_tl) begin
      $display("FAIL reload_old_th: got %h want FFFFFFFC", mem_read_data); errors++;
    end
    bus_write(MB + 32'h4, 32'd5);
    peek(MB + 32'h4);
    vectors++;
    if (mem_read_data !== 32'd5) begin
      $display("FAIL tl_write: got %h want 5", mem_read_data); errors++;
    end
    tick();
    peek(MB + 32'h4);
    vectors++;
    if (mem_read_data !== 32'd6) begin
      $display("FAIL tl_after_write: got %h want 6", mem_read_data); errors++;
    end
  endtask

  task automatic test_decode();
    bit v;
    peek(MB + 32'h20);
    vectors++;
    if (mem_read_data !== 32'h0) begin
      $display("FAIL unmapped_4000_0020: got %h want 0", mem_read_data); errors++;
    end
    peek(32'h2000_0000);
    vectors++;
    if (mem_read_data !== 32'h0) begin
      $display("FAIL unmapped_2000_0000: got %h want 0", mem_read_data); errors++;
    end
    bus_write(MB + 32'hC, 32'h1A5);
    vectors++;
    if (leds !== 8'hA5) begin
      $display("FAIL led_write: got %h want A5", leds); errors++;
    end
    peek(MB + 32'hC);
    vectors++;
    if (mem_read_data !== 32'h0000_00A5) begin
      $display("FAIL led_read: got %h want 000000A5", mem_read_data); errors++;
    end
    bus_write(MB + 32'h14, 32'h0);
    peek(MB + 32'h14);
    vectors++;
    if (mem_read_data !== model_read(MB + 32'h14, v)) begin
      $display("FAIL systick_ro: got %h want %h", mem_read_data, m_systick); errors++;
    end
  endtask

  task automatic test_random();
    logic [31:0] a, exp;
    bit v;
    int kind;
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0)      a = DB + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      else if (kind == 1) a = MB + 32'(4 * $urandom_range(0, 7));
      else if ($urandom_range(0, 1) == 1) a = MB + 32'h20 + 32'($urandom_range(0, 255));
      else                a = 32'h2000_0000 | 32'($urandom);
      peek(a);
      exp = model_read(a, v);
      if (v) begin
        vectors++;
        if (mem_read_data !== exp) begin
          $display("FAIL rand_read@%h: got %h want %h", a, mem_read_data, exp); errors++;
        end
      end
      vectors++;
      if ({irq, leds, digits} !== {m_tcon[2], m_led, m_digi}) begin
        $display("FAIL rand_outputs: got %b/%h/%h want %b/%h/%h", irq, leds, digits, m_tcon[2], m_led, m_digi);
        errors++;
      end
      case ($urandom_range(0, 5))
        0, 1: bus_write(DB + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3)), $urandom);
        2:    bus_write(MB + 32'(4 * $urandom_range(0, 5)), $urandom);
        3:    bus_write(MB + 32'h20 + 32'(4 * $urandom_range(0, 7)), $urandom);
        default: tick();
      endcase
    end
  endtask

  task automatic test_reset_mid_run();
    bit v;
    bus_write(MB + 32'hC, 32'hFF);
    bus_write(MB + 32'h10, 32'hFFF);
    bus_write(MB + 32'h4, 32'hFFFF_FFFF);
    bus_write(MB + 32'h8, 32'h3);
    tick();
`ifdef DATA_BUS_UART_TX_EN
    bus_write(MB + 32'h18, 32'h00);
    tick();
`endif
    vectors++;
    if (irq !== m_tcon[2]) begin
      $display("FAIL pre_reset_irq: got %b want %b", irq, m_tcon[2]); errors++;
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({irq, leds, digits, uart_txd} !== {1'b0, 8'h00, 12'h000, 1'b1}) begin
      $display("FAIL async_reset: got irq=%b leds=%h digits=%h txd=%b, want 0/00/000/1", irq, leds, digits, uart_txd);
      errors++;
    end
    model_reset();
    tick();
    @(negedge clk);
    reset = 1'b0;
    #1;
    tick();
    peek(MB + 32'h4);
    vectors++;
    if (mem_read_data !== 32'h0) begin
      $display("FAIL tl_after_reset: got %h want 0", mem_read_data); errors++;
    end
    peek(DB + 32'h4);
    vectors++;
    if (mem_read_data !== model_read(DB + 32'h4, v)) begin
      $display("FAIL ram_keeps_data: got %h want %h", mem_read_data, ram_m[1]); errors++;
    end
  endtask

`ifdef DATA_BUS_UART_TX_EN
  task automatic test_uart();
    logic [9:0] frame;
    frame = {1'b1, 8'h55, 1'b0};
    bus_write(MB + 32'h18, 32'h55);
    for (int i = 0; i < 40; i++) begin
      peek(MB + 32'h1C);
      vectors++;
      if (uart_txd !== frame[i / 4]) begin
        $display("FAIL uart_bit_cycle%0d: got %b want %b", i, uart_txd, frame[i / 4]); errors++;
      end
      vectors++;
      if (mem_read_data !== 32'h1) begin
        $display("FAIL uart_busy_cycle%0d: got %h want 1", i, mem_read_data); errors++;
      end
      if (i == 10) begin
        mem_write = 1'b1; mem_address = MB + 32'h18; mem_write_data = 32'hFF;
      end
      tick();
      mem_write = 1'b0;
    end
    peek(MB + 32'h1C);
    vectors++;
    if (mem_read_data !== 32'h0 || uart_txd !== 1'b1) begin
      $display("FAIL uart_done: got stat=%h txd=%b want 0/1", mem_read_data, uart_txd); errors++;
    end
  endtask
`else
  task automatic test_uart();
    bus_write(MB + 32'h18, 32'h55);
    for (int i = 0; i < 8; i++) begin
      peek(MB + 32'h18 + 32'(4 * (i % 2)));
      vectors++;
      if (uart_txd !== 1'b1 || mem_read_data !== 32'h0) begin
        $display("FAIL uart_absent_cycle%0d: got txd=%b rd=%h want 1/0", i, uart_txd, mem_read_data); errors++;
      end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ram();
    test_timer();
    test_collision();
    test_decode();
    test_random();
    test_reset_mid_run();
    test_uart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
